// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble binary-to-BCD converter, one shift/add-3 step per clock.
// Optional build macro BCD_SATURATE_EN: clamp overflowing results to all nines.
module bin_to_bcd_serial #(
  parameter int IN_WIDTH   = 32,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [IN_WIDTH-1:0]     bin_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    valid_out,
  output logic                    ovf_out
);

  // Decimal digits needed to hold 2^w-1, i.e. ceil(w*log10(2)).
  function automatic int calc_digits(input int w);
    longint unsigned v;
    int d;
    v = (64'd1 << w) - 64'd1;
    d = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 0) begin
        v = v / 10;
        d = d + 1;
      end
    end
    return d;
  endfunction

  localparam int FULL_DIGITS = calc_digits(IN_WIDTH);
  localparam int ACC_DIGITS  = (FULL_DIGITS > NUM_DIGITS) ? FULL_DIGITS : NUM_DIGITS;
  localparam int ACC_W       = 4 * ACC_DIGITS;
  localparam int OUT_W       = 4 * NUM_DIGITS;
  localparam int CNT_W       = $clog2(IN_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state, state_next;
  logic [IN_WIDTH-1:0] shift_reg;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_adj;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last_shift;
  logic               overflow;
  logic [OUT_W-1:0]   result;

  assign ready_out  = (state == IDLE);
  assign accept     = valid_in && ready_out;
  assign last_shift = (cnt == CNT_W'(IN_WIDTH - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      // NOTE: every clocked register uses <= so all flops sample the pre-edge
      // values together; a blocking = here would create an order-dependent race.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next; a missing branch
    // would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (accept)     state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Add-3 correction on every nibble that would exceed 9 after doubling.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < ACC_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Any nonzero digit above the displayed ones means the value did not fit.
  always_comb begin
    overflow = 1'b0;
    for (int i = NUM_DIGITS; i < ACC_DIGITS; i++) begin
      overflow = overflow | (acc[4*i +: 4] != 4'd0);
    end
  end

`ifdef BCD_SATURATE_EN
  assign result = overflow ? {NUM_DIGITS{4'h9}} : acc[OUT_W-1:0];
`else
  assign result = acc[OUT_W-1:0];
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shift_reg <= '0;
      acc       <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      valid_out <= 1'b0;
      ovf_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= bin_in;
            acc       <= '0;
            cnt       <= '0;
          end
        end
        SHIFT: begin
          {acc, shift_reg} <= {acc_adj, shift_reg} << 1;
          cnt              <= cnt + CNT_W'(1);
        end
        DONE: begin
          bcd_out   <= result;
          ovf_out   <= overflow;
          valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Directed self-checking bench for bin_to_bcd_serial at default parameters.
// Expected values follow BCD_SATURATE_EN when the bench is built with it.
module tb_bin_to_bcd_serial;

  localparam int IN_WIDTH   = 32;
  localparam int NUM_DIGITS = 8;

  logic                    clk_in;
  logic                    rst_n_in;
  logic [IN_WIDTH-1:0]     bin_in;
  logic                    valid_in;
  logic                    ready_out;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic                    valid_out;
  logic                    ovf_out;

  int n_vec;
  int n_err;

  bin_to_bcd_serial #(
    .IN_WIDTH  (IN_WIDTH),
    .NUM_DIGITS(NUM_DIGITS)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bin_in   (bin_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .bcd_out  (bcd_out),
    .valid_out(valid_out),
    .ovf_out  (ovf_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

`ifdef BCD_SATURATE_EN
  localparam logic [31:0] EXP_1E8  = 32'h99999999;
  localparam logic [31:0] EXP_FFFF = 32'h99999999;
`else
  localparam logic [31:0] EXP_1E8  = 32'h00000000;
  localparam logic [31:0] EXP_FFFF = 32'h94967295;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference conversion of values below 10^8 for the streaming test.
  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic wait_ready(input string tag);
    int ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (ready_out === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk_in);
    end
    check({tag, "_ready_wait"}, 64'(ok), 64'd1);
  endtask

  // Entered and left on a falling edge.
  task automatic convert(input string tag, input logic [31:0] value,
                         input logic [31:0] exp_bcd, input logic exp_ovf);
    int lat;
    wait_ready(tag);
    bin_in   = value;
    valid_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    valid_in = 1'b0;
    bin_in   = ~value;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (k == 1) check({tag, "_busy"}, 64'(ready_out), 64'd0);
      if (valid_out === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'd33);
    check({tag, "_bcd"}, 64'(bcd_out), 64'(exp_bcd));
    check({tag, "_ovf"}, 64'(ovf_out), 64'(exp_ovf));
    @(posedge clk_in);
    @(negedge clk_in);
    check({tag, "_pulse_end"}, 64'(valid_out), 64'd0);
    check({tag, "_hold"}, 64'(bcd_out), 64'(exp_bcd));
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] v;
    int          acc_cnt;
    int          res_cnt;
    int          last_acc;
    int          seen;

    n_vec    = 0;
    n_err    = 0;
    rst_n_in = 1'b0;
    bin_in   = '0;
    valid_in = 1'b0;
    #1;
    check("reset_ready", 64'(ready_out), 64'd1);
    check("reset_valid", 64'(valid_out), 64'd0);
    check("reset_bcd", 64'(bcd_out), 64'd0);
    check("reset_ovf", 64'(ovf_out), 64'd0);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    convert("zero",     32'd0,         32'h00000000, 1'b0);
    convert("nine",     32'd9,         32'h00000009, 1'b0);
    convert("ten",      32'd10,        32'h00000010, 1'b0);
    convert("12345678", 32'd12345678,  32'h12345678, 1'b0);
    convert("99999999", 32'd99999999,  32'h99999999, 1'b0);
    convert("1e8",      32'd100000000, EXP_1E8,      1'b1);
    convert("back2ok",  32'd305,       32'h00000305, 1'b0);

    // valid_in held high with bin_in changing every cycle.
    acc_cnt  = 0;
    res_cnt  = 0;
    last_acc = -1;
    for (int c = 0; c < 300 && res_cnt < 3; c++) begin
      if (valid_out === 1'b1) begin
        if (exp_q.size() > 0) begin
          check("stream_bcd", 64'(bcd_out), 64'(exp_q.pop_front()));
          check("stream_ovf", 64'(ovf_out), 64'd0);
        end else begin
          check("stream_extra_valid", 64'(valid_out), 64'd0);
        end
        res_cnt++;
      end
      if (acc_cnt < 3) begin
        v        = 32'(5000 + c * 1237);
        bin_in   = v;
        valid_in = 1'b1;
        if (ready_out === 1'b1) begin
          exp_q.push_back(to_bcd(v));
          if (last_acc >= 0) check("stream_gap", 64'(c - last_acc), 64'd34);
          last_acc = c;
          acc_cnt++;
        end
      end else begin
        valid_in = 1'b0;
      end
      @(posedge clk_in);
      @(negedge clk_in);
    end
    valid_in = 1'b0;
    check("stream_results", 64'(res_cnt), 64'd3);

    convert("ffffffff", 32'hFFFFFFFF, EXP_FFFF, 1'b1);

    // Reset in the middle of converting 42.
    wait_ready("abort");
    bin_in   = 32'd42;
    valid_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    valid_in = 1'b0;
    repeat (9) @(posedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("abort_ready", 64'(ready_out), 64'd1);
    check("abort_valid", 64'(valid_out), 64'd0);
    check("abort_bcd", 64'(bcd_out), 64'd0);
    check("abort_ovf", 64'(ovf_out), 64'd0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (valid_out === 1'b1) seen++;
    end
    check("abort_no_pulse", 64'(seen), 64'd0);
    check("abort_bcd_held", 64'(bcd_out), 64'd0);

    convert("after_abort", 32'd7, 32'h00000007, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
